// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, a 2-entry skid buffer,
// synchronous flush and a saturating back-pressure stall counter.
module pipe_stage_reg #(
  parameter int DW   = 16,
  parameter int PCW  = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_aluout,
  input  logic [PCW-1:0]  in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_aluout,
  output logic [PCW-1:0]  out_pc,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [DW-1:0]   r_mainAluout;
  logic [PCW-1:0]  r_mainPc;
  logic [DW-1:0]   r_skidAluout;
  logic [PCW-1:0]  r_skidPc;
  logic [CNTW-1:0] r_stallCnt;
  logic            w_accept;
  logic            w_fire;
  logic            w_loadMainFromIn;
  logic            w_loadMainFromSkid;
  logic            w_loadSkid;
  logic            w_stall;

  // Ready depends only on registered occupancy, so out_ready never reaches in_ready.
  assign in_ready   = (r_state != S_TWO) && !rst;
  assign out_valid  = (r_state != S_EMPTY);
  assign out_aluout = r_mainAluout;
  assign out_pc     = r_mainPc;
  assign stall_cnt  = r_stallCnt;

  assign w_accept = in_valid && in_ready;
  assign w_fire   = out_valid && out_ready;
  assign w_stall  = out_valid && !out_ready;

  always_comb begin
    w_nextState        = r_state;
    w_loadMainFromIn   = 1'b0;
    w_loadMainFromSkid = 1'b0;
    w_loadSkid         = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_nextState      = S_ONE;
          w_loadMainFromIn = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_fire) begin
          w_loadMainFromIn = 1'b1;
        end else if (w_accept) begin
          w_nextState = S_TWO;
          w_loadSkid  = 1'b1;
        end else if (w_fire) begin
          w_nextState = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_fire) begin
          w_nextState        = S_ONE;
          w_loadMainFromSkid = 1'b1;
        end
      end
      default: w_nextState = S_EMPTY;
    endcase
  end

  // Flush wins over any accept in the same cycle; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_mainAluout <= '0;
      r_mainPc     <= '0;
      r_skidAluout <= '0;
      r_skidPc     <= '0;
    end else if (flush) begin
      r_state      <= S_EMPTY;
      r_mainAluout <= '0;
      r_mainPc     <= '0;
      r_skidAluout <= '0;
      r_skidPc     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadMainFromIn) begin
        r_mainAluout <= in_aluout;
        r_mainPc     <= in_pc;
      end else if (w_loadMainFromSkid) begin
        r_mainAluout <= r_skidAluout;
        r_mainPc     <= r_skidPc;
      end
      if (w_loadSkid) begin
        r_skidAluout <= in_aluout;
        r_skidPc     <= in_pc;
      end
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != {CNTW{1'b1}})) begin
      r_stallCnt <= r_stallCnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for pipe_stage_reg (CNTW=3 to reach saturation quickly),
// followed by a bounded FIFO-order sequence under toggling back-pressure.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_aluout;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_aluout;
  logic [31:0] out_pc;
  logic [2:0]  stall_cnt;

  int vectors;
  int miscompares;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [15:0] ia;
    logic [31:0] ipc;
    logic        ordy;
    logic        chk;
    logic        ev;
    logic [15:0] ea;
    logic [31:0] epc;
    logic        eir;
    logic [2:0]  ecnt;
  } vec_t;

  localparam int NVEC = 42;
  vec_t tbl [NVEC];

  pipe_stage_reg #(.DW(16), .PCW(32), .CNTW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_aluout  (in_aluout),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_aluout (out_aluout),
    .out_pc     (out_pc),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [15:0] ia,
                              input logic [31:0] ipc, input logic ordy, input logic chk, input logic ev,
                              input logic [15:0] ea, input logic [31:0] epc, input logic eir,
                              input logic [2:0] ecnt);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.ia = ia; t.ipc = ipc; t.ordy = ordy;
    t.chk = chk; t.ev = ev; t.ea = ea; t.epc = epc; t.eir = eir; t.ecnt = ecnt;
    return t;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    rst       = t.rst;
    flush     = t.flush;
    in_valid  = t.iv;
    in_aluout = t.ia;
    in_pc     = t.ipc;
    out_ready = t.ordy;
    #1;
  endtask

  task automatic checkOutput(input int idx, input vec_t t);
    if (t.chk) begin
      vectors++;
      if (out_valid !== t.ev) begin
        miscompares++;
        $display("[TB] FAIL vec%0d out_valid got %b want %b", idx, out_valid, t.ev);
      end
      if (out_aluout !== t.ea) begin
        miscompares++;
        $display("[TB] FAIL vec%0d out_aluout got %h want %h", idx, out_aluout, t.ea);
      end
      if (out_pc !== t.epc) begin
        miscompares++;
        $display("[TB] FAIL vec%0d out_pc got %h want %h", idx, out_pc, t.epc);
      end
      if (in_ready !== t.eir) begin
        miscompares++;
        $display("[TB] FAIL vec%0d in_ready got %b want %b", idx, in_ready, t.eir);
      end
      if (stall_cnt !== t.ecnt) begin
        miscompares++;
        $display("[TB] FAIL vec%0d stall_cnt got %0d want %0d", idx, stall_cnt, t.ecnt);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_aluout = '0; in_pc = '0; out_ready = 1'b0;

    //                 rst flush iv ia        ipc        ordy chk ev ea        epc        ir cnt
    // Reset held with a beat offered, then released
    tbl[0]  = mk(1, 0, 1, 16'h0011, 32'h100, 0, 0, 0, 16'h0000, 32'h000, 0, 0);
    tbl[1]  = mk(1, 0, 1, 16'h0011, 32'h100, 0, 1, 0, 16'h0000, 32'h000, 0, 0);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h0000, 32'h000, 1, 0);
    // Back-to-back streaming with out_ready high
    tbl[3]  = mk(0, 0, 1, 16'h0011, 32'h100, 1, 1, 0, 16'h0000, 32'h000, 1, 0);
    tbl[4]  = mk(0, 0, 1, 16'h0022, 32'h104, 1, 1, 1, 16'h0011, 32'h100, 1, 0);
    tbl[5]  = mk(0, 0, 1, 16'h0033, 32'h108, 1, 1, 1, 16'h0022, 32'h104, 1, 0);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 1, 16'h0033, 32'h108, 1, 0);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h0033, 32'h108, 1, 0);
    // Fill skid, hold C while full, then drain A,B,C
    tbl[8]  = mk(0, 0, 1, 16'h00AA, 32'h200, 0, 1, 0, 16'h0033, 32'h108, 1, 0);
    tbl[9]  = mk(0, 0, 1, 16'h00BB, 32'h204, 0, 1, 1, 16'h00AA, 32'h200, 1, 0);
    tbl[10] = mk(0, 0, 1, 16'h00CC, 32'h208, 0, 1, 1, 16'h00AA, 32'h200, 0, 1);
    tbl[11] = mk(0, 0, 1, 16'h00CC, 32'h208, 0, 1, 1, 16'h00AA, 32'h200, 0, 2);
    tbl[12] = mk(0, 0, 1, 16'h00CC, 32'h208, 0, 1, 1, 16'h00AA, 32'h200, 0, 3);
    tbl[13] = mk(0, 0, 1, 16'h00CC, 32'h208, 1, 1, 1, 16'h00AA, 32'h200, 0, 4);
    tbl[14] = mk(0, 0, 1, 16'h00CC, 32'h208, 1, 1, 1, 16'h00BB, 32'h204, 1, 4);
    tbl[15] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 1, 16'h00CC, 32'h208, 1, 4);
    tbl[16] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h00CC, 32'h208, 1, 4);
    // Flush while full with a beat offered: the offered beat is dropped
    tbl[17] = mk(0, 0, 1, 16'h0111, 32'h300, 0, 1, 0, 16'h00CC, 32'h208, 1, 4);
    tbl[18] = mk(0, 0, 1, 16'h0222, 32'h304, 0, 1, 1, 16'h0111, 32'h300, 1, 4);
    tbl[19] = mk(0, 1, 1, 16'h0EEE, 32'h308, 0, 1, 1, 16'h0111, 32'h300, 0, 5);
    tbl[20] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h0000, 32'h000, 1, 6);
    tbl[21] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h0000, 32'h000, 1, 6);
    // Stall counter saturation at 7, unaffected by flush
    tbl[22] = mk(1, 0, 0, 16'h0000, 32'h000, 0, 1, 0, 16'h0000, 32'h000, 0, 6);
    tbl[23] = mk(0, 0, 1, 16'h0777, 32'h400, 0, 1, 0, 16'h0000, 32'h000, 1, 0);
    for (int i = 0; i < 10; i++)
      tbl[24+i] = mk(0, 0, 0, 16'h0000, 32'h000, 0, 1, 1, 16'h0777, 32'h400, 1,
                     (i < 7) ? 3'(i) : 3'd7);
    tbl[34] = mk(0, 1, 0, 16'h0000, 32'h000, 0, 1, 1, 16'h0777, 32'h400, 1, 7);
    tbl[35] = mk(0, 0, 0, 16'h0000, 32'h000, 0, 1, 0, 16'h0000, 32'h000, 1, 7);
    // Reset pulse while full, then a single beat emerges alone
    tbl[36] = mk(0, 0, 1, 16'h0AAA, 32'h500, 0, 1, 0, 16'h0000, 32'h000, 1, 7);
    tbl[37] = mk(0, 0, 1, 16'h0BBB, 32'h504, 0, 1, 1, 16'h0AAA, 32'h500, 1, 7);
    tbl[38] = mk(1, 0, 0, 16'h0000, 32'h000, 0, 1, 1, 16'h0AAA, 32'h500, 0, 7);
    tbl[39] = mk(0, 0, 1, 16'h0055, 32'h600, 1, 1, 0, 16'h0000, 32'h000, 1, 0);
    tbl[40] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 1, 16'h0055, 32'h600, 1, 0);
    tbl[41] = mk(0, 0, 0, 16'h0000, 32'h000, 1, 1, 0, 16'h0055, 32'h600, 1, 0);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(i, tbl[i]);
    end

    // Six beats through toggling back-pressure must arrive in order, bounded to 60 cycles
    begin
      int sent;
      int got;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
        @(negedge clk);
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = (sent < 6);
        in_aluout = 16'h1000 + 16'(sent);
        in_pc     = 32'h700 + 32'(4 * sent);
        out_ready = (cyc % 3) != 0;
        #1;
        if (out_valid && out_ready) begin
          vectors++;
          if (out_aluout !== 16'h1000 + 16'(got) || out_pc !== 32'h700 + 32'(4 * got)) begin
            miscompares++;
            $display("[TB] FAIL order beat%0d got %h/%h want %h/%h", got, out_aluout, out_pc,
                     16'h1000 + 16'(got), 32'h700 + 32'(4 * got));
          end
          got++;
        end
        if (in_valid && in_ready) sent++;
      end
      vectors++;
      if (got != 6) begin
        miscompares++;
        $display("[TB] FAIL order_timeout got %0d beats want 6", got);
      end
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
